// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and pipeline control outputs of the sequencer
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
);
    logic [3:0]      id_opcode;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            ex_memread;
    logic [RA_W-1:0] ex_rd;
    logic            ex_branch_taken;
    logic            mem_access;
    logic            mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             pipe_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_opcode, id_rs1, id_rs2, ex_memread, ex_rd,
               ex_branch_taken, mem_access, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               pipe_en, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, ex_memread, ex_rd,
               ex_branch_taken, mem_access, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               pipe_en, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, branch flush and memory-wait freeze sequencer
module pipe_hazard_ctrl #(
    parameter int RA_W    = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t           state;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic use_rs1;
    logic use_rs2;
    logic freeze;
    logic flush;
    logic lu;

    logic pc_en_c;
    logic ifid_en_c;
    logic ifid_flush_c;
    logic idex_en_c;
    logic idex_flush_c;
    logic pipe_en_c;
    logic halted_c;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (hz.id_opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h6: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            4'h4, 4'h5: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign freeze = (state != HALT) && hz.mem_access && !hz.mem_ready;
    assign flush  = (state != HALT) && !freeze && hz.ex_branch_taken;
    assign lu     = (state != HALT) && !freeze && !flush && hz.ex_memread &&
                    ((use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                     (use_rs2 && (hz.ex_rd == hz.id_rs2)));

    // Reset forces both flushes so the pipeline registers fill with NOPs/bubbles.
    always_comb begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b0;
        idex_flush_c = 1'b0;
        pipe_en_c    = 1'b0;
        halted_c     = 1'b0;
        if (!rst_n) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (state == HALT) begin
            halted_c = 1'b1;
        end else if (freeze) begin
            pc_en_c = 1'b0;
        end else if (flush) begin
            pc_en_c      = 1'b1;
            ifid_en_c    = 1'b1;
            ifid_flush_c = 1'b1;
            idex_en_c    = 1'b1;
            idex_flush_c = 1'b1;
            pipe_en_c    = 1'b1;
        end else if (lu) begin
            idex_en_c    = 1'b1;
            idex_flush_c = 1'b1;
            pipe_en_c    = 1'b1;
        end else begin
            pc_en_c   = 1'b1;
            ifid_en_c = 1'b1;
            idex_en_c = 1'b1;
            pipe_en_c = 1'b1;
        end
    end

    // wait_cnt holds the number of not-ready cycles already completed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        wait_cnt <= 8'd1;
                        state    <= (TMO == 8'd1) ? HALT : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (freeze) begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 == TMO) begin
                            state <= HALT;
                        end
                    end else begin
                        wait_cnt <= 8'd0;
                        state    <= RUN;
                    end
                end
                default: state <= HALT;
            endcase

            if (state != HALT) begin
                if ((freeze || lu) && (stall_q != '1)) begin
                    stall_q <= stall_q + CNT_W'(1);
                end
                if (flush && (flush_q != '1)) begin
                    flush_q <= flush_q + CNT_W'(1);
                end
            end
        end
    end

    assign hz.pc_en      = pc_en_c;
    assign hz.ifid_en    = ifid_en_c;
    assign hz.ifid_flush = ifid_flush_c;
    assign hz.idex_en    = idex_en_c;
    assign hz.idex_flush = idex_flush_c;
    assign hz.pipe_en    = pipe_en_c;
    assign hz.halted     = halted_c;
    assign hz.stall_cnt  = stall_q;
    assign hz.flush_cnt  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int RA_W = 3;
    localparam int CW   = 4;
    localparam int TMO  = 4;
    localparam int SAT  = 15;

    localparam logic [6:0] O_RST    = 7'b0010100;
    localparam logic [6:0] O_HALT   = 7'b0000001;
    localparam logic [6:0] O_FREEZE = 7'b0000000;
    localparam logic [6:0] O_FLUSH  = 7'b1111110;
    localparam logic [6:0] O_LU     = 7'b0001110;
    localparam logic [6:0] O_NORM   = 7'b1101010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int m_stall = 0;
    int m_flush = 0;
    int m_wait = 0;
    bit m_halt = 1'b0;

    pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    wire [6:0] obs = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en,
                      hz.idex_flush, hz.pipe_en, hz.halted};

    function automatic bit dep_hit();
        int nsrc;
        int op = int'(hz.id_opcode);
        if (op <= 3 || op == 6) nsrc = 2;
        else if (op == 4 || op == 5) nsrc = 1;
        else nsrc = 0;
        return hz.ex_memread &&
               ((nsrc >= 1 && hz.ex_rd == hz.id_rs1) || (nsrc == 2 && hz.ex_rd == hz.id_rs2));
    endfunction

    function automatic bit is_frozen();
        return !m_halt && hz.mem_access && !hz.mem_ready;
    endfunction

    function automatic logic [6:0] exp_out();
        if (!rst_n) return O_RST;
        if (m_halt) return O_HALT;
        if (is_frozen()) return O_FREEZE;
        if (hz.ex_branch_taken) return O_FLUSH;
        if (dep_hit()) return O_LU;
        return O_NORM;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_halt = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else if (!m_halt) begin
            if (is_frozen()) begin
                m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
                m_wait++;
                if (m_wait >= TMO) m_halt = 1'b1;
            end else begin
                m_wait = 0;
                if (hz.ex_branch_taken) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
                else if (dep_hit()) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        hz.id_opcode = 4'hF; hz.id_rs1 = '0; hz.id_rs2 = '0;
        hz.ex_memread = 1'b0; hz.ex_rd = '0; hz.ex_branch_taken = 1'b0;
        hz.mem_access = 1'b0; hz.mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== O_RST) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, O_RST); end
        tick();
        checks++;
        if (hz.stall_cnt !== 4'd0 || hz.flush_cnt !== 4'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hz.stall_cnt, hz.flush_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== O_NORM) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, O_NORM); end
    endtask

    task automatic test_load_use();
        do_reset();
        hz.id_opcode = 4'h0; hz.id_rs1 = 3'd2; hz.id_rs2 = 3'd5;
        hz.ex_memread = 1'b1; hz.ex_rd = 3'd2;
        #1;
        checks++;
        if (obs !== O_LU) begin failures++; $display("FAIL lu_bubble got=%b exp=%b", obs, O_LU); end
        tick();
        hz.ex_memread = 1'b0;
        #1;
        checks++;
        if (obs !== O_NORM || hz.stall_cnt !== 4'd1) begin
            failures++; $display("FAIL lu_single got=%b/%0d exp=%b/1", obs, hz.stall_cnt, O_NORM);
        end
        tick();
        hz.id_opcode = 4'hF; hz.ex_memread = 1'b1;
        #1;
        checks++;
        if (obs !== O_NORM) begin failures++; $display("FAIL lu_nop got=%b exp=%b", obs, O_NORM); end
        tick();
        hz.id_opcode = 4'h4; hz.id_rs1 = 3'd1; hz.id_rs2 = 3'd2;
        #1;
        checks++;
        if (obs !== O_NORM) begin failures++; $display("FAIL lu_rs2_unused got=%b exp=%b", obs, O_NORM); end
        tick();
        hz.id_opcode = 4'h6;
        #1;
        checks++;
        if (obs !== O_LU) begin failures++; $display("FAIL lu_store_data got=%b exp=%b", obs, O_LU); end
        tick();
        checks++;
        if (hz.stall_cnt !== 4'd2) begin failures++; $display("FAIL lu_count got=%0d exp=2", hz.stall_cnt); end
    endtask

    task automatic test_branch_lu();
        do_reset();
        hz.id_opcode = 4'h1; hz.id_rs1 = 3'd3; hz.ex_memread = 1'b1; hz.ex_rd = 3'd3;
        hz.ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (obs !== O_FLUSH) begin failures++; $display("FAIL branch_flush got=%b exp=%b", obs, O_FLUSH); end
        tick();
        checks++;
        if (hz.flush_cnt !== 4'd1 || hz.stall_cnt !== 4'd0) begin
            failures++; $display("FAIL branch_counts got=%0d/%0d exp=1/0", hz.flush_cnt, hz.stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        hz.mem_access = 1'b1; hz.mem_ready = 1'b0; hz.ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== O_FREEZE) begin failures++; $display("FAIL wait_freeze%0d got=%b exp=%b", i, obs, O_FREEZE); end
            tick();
        end
        hz.mem_ready = 1'b1; hz.ex_branch_taken = 1'b0;
        #1;
        checks++;
        if (obs !== O_NORM) begin failures++; $display("FAIL wait_release got=%b exp=%b", obs, O_NORM); end
        tick();
        checks++;
        if (hz.stall_cnt !== 4'd3 || hz.flush_cnt !== 4'd0) begin
            failures++; $display("FAIL wait_count got=%0d/%0d exp=3/0", hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        hz.mem_access = 1'b1; hz.mem_ready = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            #1;
            checks++;
            if (obs !== O_FREEZE) begin failures++; $display("FAIL tmo_freeze%0d got=%b exp=%b", i, obs, O_FREEZE); end
            tick();
        end
        checks++;
        if (obs !== O_HALT) begin failures++; $display("FAIL tmo_halt got=%b exp=%b", obs, O_HALT); end
        hz.mem_ready = 1'b1; hz.ex_branch_taken = 1'b1;
        #1;
        tick();
        checks++;
        if (obs !== O_HALT || hz.stall_cnt !== 4'd4 || hz.flush_cnt !== 4'd0) begin
            failures++; $display("FAIL tmo_sticky got=%b/%0d/%0d exp=%b/4/0", obs, hz.stall_cnt, hz.flush_cnt, O_HALT);
        end
    endtask

    task automatic test_reset_halt();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== O_RST) begin failures++; $display("FAIL rsthalt_forced got=%b exp=%b", obs, O_RST); end
        tick();
        rst_n = 1'b1;
        set_idle();
        #1;
        checks++;
        if (obs !== O_NORM || hz.stall_cnt !== 4'd0 || hz.flush_cnt !== 4'd0) begin
            failures++; $display("FAIL rsthalt_run got=%b/%0d/%0d exp=%b/0/0", obs, hz.stall_cnt, hz.flush_cnt, O_NORM);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        hz.id_opcode = 4'h2; hz.id_rs1 = 3'd1; hz.id_rs2 = 3'd7;
        hz.ex_memread = 1'b1; hz.ex_rd = 3'd7;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (hz.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall got=%0d exp=15", hz.stall_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rst_n              = ($urandom_range(0, 79) != 0);
            hz.id_opcode       = 4'($urandom);
            hz.id_rs1          = 3'($urandom_range(0, 3));
            hz.id_rs2          = 3'($urandom_range(0, 3));
            hz.ex_rd           = 3'($urandom_range(0, 3));
            hz.ex_memread      = 1'($urandom);
            hz.ex_branch_taken = ($urandom_range(0, 4) == 0);
            hz.mem_access      = 1'($urandom);
            hz.mem_ready       = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (obs !== exp_out()) begin
                failures++; $display("FAIL rand_out cyc=%0d got=%b exp=%b", i, obs, exp_out());
            end
            tick();
            checks++;
            if (hz.stall_cnt !== 4'(m_stall) || hz.flush_cnt !== 4'(m_flush)) begin
                failures++;
                $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        set_idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_reset_halt();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the RISC-8 pipelined processor, sitting beside the decode stage and driving the enable and flush controls of every pipeline register and the PC. It detects load-use hazards from the ID-stage opcode and register fields and inserts one bubble. It flushes the two younger instructions when a branch resolves taken in EX. It freezes the whole pipeline while the data memory withholds `mem_ready`, and halts with a sticky error if the wait exceeds a bound.

## Interface
- `RA_W`, 3: register address width.
- `CNT_W`, 16: width of the performance counters.
- `TIMEOUT`, 64: maximum consecutive memory-wait cycles before halt; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_opcode` in 4: opcode of the instruction in ID.
- `id_rs1` in RA_W: source register 1 of the instruction in ID.
- `id_rs2` in RA_W: source register 2 of the instruction in ID.
- `ex_memread` in 1: ID/EX stage holds a load.
- `ex_rd` in RA_W: destination register of the ID/EX instruction.
- `ex_branch_taken` in 1: branch in EX resolved taken this cycle.
- `mem_access` in 1: MEM stage holds a load or store.
- `mem_ready` in 1: data memory completes the MEM-stage access this cycle.
- `pc_en` out 1: PC update enable.
- `ifid_en` out 1: IF/ID write enable.
- `ifid_flush` out 1: IF/ID clear to NOP (opcode 4'hF).
- `idex_en` out 1: ID/EX write enable.
- `idex_flush` out 1: ID/EX clear to bubble (all controls 0).
- `pipe_en` out 1: EX/MEM and MEM/WB write enable.
- `halted` out 1: sticky timeout error.
- `stall_cnt` out CNT_W: bubble plus freeze cycles, saturating.
- `flush_cnt` out CNT_W: taken-branch flush events, saturating.

## Operation
- **Source usage by opcode:**
  - 0x0–0x3 use rs1 and rs2.
  - 0x4 and 0x5 use rs1.
  - 0x6 uses rs1 (base) and rs2 (store data).
  - 0xF and undefined opcodes use none.
- **States:** RUN, MEM_WAIT, HALT. A 8-bit `wait_cnt` is kept alongside the state.
- **freeze** = (RUN or MEM_WAIT) & `mem_access` & !`mem_ready`.
  - Drives `pc_en` = `ifid_en` = `idex_en` = `pipe_en` = 0 and both flushes = 0.
  - Suppresses branch and load-use actions.
- **flush** = !freeze & `ex_branch_taken`.
  - Outputs: `pc_en`=1, `ifid_flush`=1, `idex_flush`=1, `ifid_en`=1, `idex_en`=1.
  - `flush_cnt` +1.
  - Takes priority over load-use.
- **lu** = !freeze & !flush & `ex_memread` & `ex_rd` equals a used source.
  - Outputs: `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `idex_en`=1.
  - `stall_cnt` +1.
- **Otherwise:** all enables 1, flushes 0.
- **Transitions:**
  - RUN → MEM_WAIT on freeze; `wait_cnt`←1.
  - In MEM_WAIT, while `mem_ready`=0: `wait_cnt`+1. If `wait_cnt`==TIMEOUT, go to HALT.
  - MEM_WAIT with `mem_ready`=1 → RUN. This cycle is not frozen; the normal rules apply.
  - HALT: all enables 0, flushes 0, `halted`=1. Exit only by reset.
- **Counters:**
  - `stall_cnt` +1 in every freeze cycle and every lu cycle.
  - Both counters saturate at all-ones.
  - Both counters hold in HALT.
- **Reset:** while `rst_n`=0, outputs are forced: enables 0, `ifid_flush`=`idex_flush`=1, `halted`=0. On the next edge: state RUN, `wait_cnt`=0, counters 0.

## Timing
- All hazard outputs are combinational from the current state and inputs, with zero-cycle latency. State and counters are registered.
- **Load-use:** exactly one bubble. The dependent instruction re-enters ID/EX on the following cycle, when `ex_memread` is 0.
- **Taken branch:** 2-cycle penalty (IF/ID and ID/EX squashed). Flush and lu in the same cycle: flush only.
- **Memory wait of N not-ready cycles:** the pipeline freezes exactly N cycles.
- **Halt:** entered at the edge ending the TIMEOUT-th consecutive not-ready cycle. `halted` is high from the next cycle.
- **Branch or load-use during freeze:** ignored. It is re-evaluated on the release cycle because the frozen registers hold their inputs.
- **Reset mid-MEM_WAIT or in HALT:** RUN and counters 0 after one edge with `rst_n`=0.

## Test plan
- **Load-use:** ID opcode 0x0, rs1=2; `ex_memread`=1, `ex_rd`=2 → `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for 1 cycle; `stall_cnt`=1. Repeat with opcode 0xF → no stall.
- **Taken branch with coincident load-use:** `ex_branch_taken`=1 and lu true → `ifid_flush`=`idex_flush`=1, `pc_en`=1; `flush_cnt`=1; `stall_cnt` unchanged.
- **Memory wait:** `mem_access`=1, `mem_ready` low for 3 cycles then high → all enables 0 for exactly 3 cycles, release on the 4th; `stall_cnt`=3; state back to RUN.
- **Timeout:** TIMEOUT=4, `mem_ready` held low → HALT after the 4th wait cycle; `halted`=1 and enables 0 thereafter, even after `mem_ready`=1.
- **Reset:** assert `rst_n`=0 for 1 cycle in HALT → `halted`=0, counters 0, state RUN; flushes asserted while `rst_n` is low.
- **Saturation:** CNT_W=4, 20 load-use bubbles → `stall_cnt`=15.
